// File: rtl/irq_pkg.sv
// Shared constants for the platform interrupt controller: register word
// offsets and the width of a source ID.
package irq_pkg;

    localparam int ID_W = 5;

    localparam logic [5:0] IRQ_PENDING   = 6'h00;
    localparam logic [5:0] IRQ_ENABLE    = 6'h01;
    localparam logic [5:0] IRQ_MODE      = 6'h02;
    localparam logic [5:0] IRQ_THRESH    = 6'h03;
    localparam logic [5:0] IRQ_CLAIM     = 6'h04;
    localparam logic [5:0] IRQ_PRIO_BASE = 6'h08;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: synchroniser, edge detect, pending and in-service flags.
// A claim sets in_service and clears an edge pending; a new edge the same cycle wins.
module irq_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    input  logic mode_chg,
    output logic pending,
    output logic in_service
);

    logic s1_r;
    logic s2_r;
    logic s3_r;
    logic pending_r;
    logic in_service_r;
    logic edge_evt_s;
    logic pending_nxt_s;

    // Next pending value: mode change clears, edge mode latches events, level mode follows s2
    always_comb begin
        edge_evt_s    = s2_r & ~s3_r;
        pending_nxt_s = pending_r;
        if (mode_chg) begin
            pending_nxt_s = 1'b0;
        end else if (edge_mode) begin
            if (edge_evt_s) begin
                pending_nxt_s = 1'b1;
            end else if (claim) begin
                pending_nxt_s = 1'b0;
            end else begin
                pending_nxt_s = pending_r;
            end
        end else begin
            pending_nxt_s = s2_r;
        end
    end

    // Synchroniser, pending and in-service state
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r         <= 1'b0;
            s2_r         <= 1'b0;
            s3_r         <= 1'b0;
            pending_r    <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            s1_r      <= src;
            s2_r      <= s1_r;
            s3_r      <= s2_r;
            pending_r <= pending_nxt_s;
            if (claim) begin
                in_service_r <= 1'b1;
            end else if (complete) begin
                in_service_r <= 1'b0;
            end else begin
                in_service_r <= in_service_r;
            end
        end
    end

    assign pending    = pending_r;
    assign in_service = in_service_r;

endmodule

// File: rtl/irq_ctrl.sv
// Platform interrupt controller: NUM_SRC gated sources, priority arbitration,
// claim/complete bookkeeping and a word-addressed register port.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               re,
    input  logic               we,
    input  logic [5:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ei,
    output logic [ID_W-1:0]    irq_id
);

    logic [NUM_SRC-1:0] enable_r;
    logic [NUM_SRC-1:0] mode_r;
    logic [PRIO_W-1:0]  thresh_r;
    logic [PRIO_W-1:0]  prio_r [NUM_SRC];

    logic [NUM_SRC-1:0] pending_s;
    logic [NUM_SRC-1:0] in_service_s;
    logic [NUM_SRC-1:0] claim_s;
    logic [NUM_SRC-1:0] complete_s;
    logic [NUM_SRC-1:0] mode_chg_s;

    logic [PRIO_W-1:0]  best_prio_s;
    logic [ID_W-1:0]    best_id_s;
    logic [31:0]        read_data_s;
    logic               claim_rd_s;
    logic               complete_wr_s;
    logic               mode_wr_s;
    logic               wdata_unused_s;

    logic [31:0]        rdata_r;
    logic               ei_r;
    logic [ID_W-1:0]    irq_id_r;

    assign claim_rd_s     = re && (addr == IRQ_CLAIM);
    assign complete_wr_s  = we && (addr == IRQ_CLAIM);
    assign mode_wr_s      = we && (addr == IRQ_MODE);
    assign wdata_unused_s = ^wdata;

    // Max-priority scan; starting from THRESHOLD with a strict compare gives ties to the lowest index
    always_comb begin
        best_prio_s = thresh_r;
        best_id_s   = {ID_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_s[i] && enable_r[i] && !in_service_s[i] && (prio_r[i] > best_prio_s)) begin
                best_prio_s = prio_r[i];
                best_id_s   = ID_W'(i + 1);
            end else begin
                best_prio_s = best_prio_s;
            end
        end
    end

    // Per-source claim, complete and mode-change strobes
    always_comb begin
        claim_s    = {NUM_SRC{1'b0}};
        complete_s = {NUM_SRC{1'b0}};
        mode_chg_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_s[i]    = claim_rd_s && (best_id_s == ID_W'(i + 1));
            complete_s[i] = complete_wr_s && (wdata[ID_W-1:0] == ID_W'(i + 1));
            mode_chg_s[i] = mode_wr_s && (wdata[i] != mode_r[i]);
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk        (clk),
            .rst        (rst),
            .src        (src[g]),
            .edge_mode  (mode_r[g]),
            .claim      (claim_s[g]),
            .complete   (complete_s[g]),
            .mode_chg   (mode_chg_s[g]),
            .pending    (pending_s[g]),
            .in_service (in_service_s[g])
        );
    end

    // Register read mux; unmapped words and unused upper bits read 0
    always_comb begin
        read_data_s = 32'h0000_0000;
        case (addr)
            IRQ_PENDING: read_data_s[NUM_SRC-1:0] = pending_s;
            IRQ_ENABLE:  read_data_s[NUM_SRC-1:0] = enable_r;
            IRQ_MODE:    read_data_s[NUM_SRC-1:0] = mode_r;
            IRQ_THRESH:  read_data_s[PRIO_W-1:0]  = thresh_r;
            IRQ_CLAIM:   read_data_s[ID_W-1:0]    = best_id_s;
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (addr == (IRQ_PRIO_BASE + 6'(i))) begin
                        read_data_s[PRIO_W-1:0] = prio_r[i];
                    end else begin
                        read_data_s = read_data_s;
                    end
                end
            end
        endcase
    end

    // Configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_r <= {NUM_SRC{1'b0}};
            mode_r   <= {NUM_SRC{1'b0}};
            thresh_r <= {PRIO_W{1'b0}};
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_r[i] <= {PRIO_W{1'b0}};
            end
        end else if (we) begin
            case (addr)
                IRQ_ENABLE: enable_r <= wdata[NUM_SRC-1:0];
                IRQ_MODE:   mode_r   <= wdata[NUM_SRC-1:0];
                IRQ_THRESH: thresh_r <= wdata[PRIO_W-1:0];
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (addr == (IRQ_PRIO_BASE + 6'(i))) begin
                            prio_r[i] <= wdata[PRIO_W-1:0];
                        end else begin
                            prio_r[i] <= prio_r[i];
                        end
                    end
                end
            endcase
        end else begin
            enable_r <= enable_r;
        end
    end

    // Registered outputs; rdata holds its last value between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r  <= 32'h0000_0000;
            ei_r     <= 1'b0;
            irq_id_r <= {ID_W{1'b0}};
        end else begin
            ei_r     <= (best_id_s != {ID_W{1'b0}});
            irq_id_r <= best_id_s;
            if (re) begin
                rdata_r <= read_data_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign rdata  = rdata_r;
    assign ei     = ei_r;
    assign irq_id = irq_id_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a behavioural model predicts ei/irq_id every
// cycle and rdata after each read; a monitor pops and compares.
module tb_irq_ctrl;

    localparam int N  = 8;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src;
    logic          re;
    logic          we;
    logic [5:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ei;
    logic [4:0]    irq_id;

    irq_ctrl #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .clk    (clk),
        .rst    (rst),
        .src    (src),
        .re     (re),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ei     (ei),
        .irq_id (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        ei;
        bit [4:0]  id;
        bit        has_rd;
        bit [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    string       dname_q[$];
    logic [31:0] dact_q[$];
    logic [31:0] dexp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, in terms of the behavioural rules
    bit [N-1:0]  m_pend, m_ins, m_en, m_mode;
    bit [N-1:0]  m_hist1, m_hist2, m_hist3;   // src seen 1, 2, 3 edges ago
    bit [PW-1:0] m_thr;
    bit [PW-1:0] m_prio [N];

    // Highest priority level above threshold wins; within a level the lowest index wins
    function automatic int model_best();
        for (int p = (1 << PW) - 1; p > int'(m_thr); p--) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && m_en[i] && !m_ins[i] && int'(m_prio[i]) == p) return i + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit [31:0] model_read(int a, int best);
        case (a)
            0: return 32'(m_pend);
            1: return 32'(m_en);
            2: return 32'(m_mode);
            3: return 32'(m_thr);
            4: return 32'(best);
            default: begin
                if (a >= 8 && a < 8 + N) return 32'(m_prio[a - 8]);
                return 32'h0;
            end
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t       e;
        int         best;
        int         cid;
        bit [N-1:0] ev, cl, cp, mc;
        best     = model_best();
        e.ei     = (best != 0);
        e.id     = 5'(best);
        e.has_rd = re;
        e.rd     = model_read(int'(addr), best);
        if (rst) begin
            e.ei = 1'b0; e.id = 5'd0; e.rd = 32'h0;
            m_pend = '0; m_ins = '0; m_en = '0; m_mode = '0; m_thr = '0;
            m_hist1 = '0; m_hist2 = '0; m_hist3 = '0;
            for (int i = 0; i < N; i++) m_prio[i] = '0;
        end else begin
            ev = m_hist2 & ~m_hist3;
            cl = '0; cp = '0; mc = '0;
            if (re && addr == 6'd4 && best != 0) cl[best - 1] = 1'b1;
            cid = int'(wdata[4:0]);
            if (we && addr == 6'd4 && cid >= 1 && cid <= N) cp[cid - 1] = 1'b1;
            if (we && addr == 6'd2) mc = wdata[N-1:0] ^ m_mode;
            for (int i = 0; i < N; i++) begin
                if (m_mode[i]) m_pend[i] = ev[i] ? 1'b1 : (cl[i] ? 1'b0 : m_pend[i]);
                else           m_pend[i] = m_hist2[i];
                if (mc[i]) m_pend[i] = 1'b0;
            end
            m_ins = (m_ins | cl) & ~cp;
            if (we) begin
                if (addr == 6'd1) m_en   = wdata[N-1:0];
                if (addr == 6'd2) m_mode = wdata[N-1:0];
                if (addr == 6'd3) m_thr  = wdata[PW-1:0];
                if (addr >= 6'd8 && int'(addr) < 8 + N) m_prio[int'(addr) - 8] = wdata[PW-1:0];
            end
            m_hist3 = m_hist2;
            m_hist2 = m_hist1;
            m_hist1 = src;
        end
        exp_q.push_back(e);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard away from the clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("ei", 32'(ei), 32'(e.ei));
            chk("irq_id", 32'(irq_id), 32'(e.id));
            if (e.has_rd) chk("rdata", rdata, e.rd);
        end
        while (dname_q.size() > 0) begin
            chk(dname_q.pop_front(), dact_q.pop_front(), dexp_q.pop_front());
        end
    end

    task automatic dchk(string n, logic [31:0] act, logic [31:0] expv);
        dname_q.push_back(n);
        dact_q.push_back(act);
        dexp_q.push_back(expv);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        @(negedge clk);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        v = rdata;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        @(negedge clk);
        src = src | m;
        @(negedge clk);
        src = src & ~m;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int r;
        rst = 1'b1; src = '0; re = 1'b0; we = 1'b0; addr = 6'd0; wdata = 32'h0;
        idle(3);
        rst = 1'b0;
        rd(6'd0, v); dchk("reset_pending", v, 32'h0);
        rd(6'd1, v); dchk("reset_enable", v, 32'h0);

        // Edge mode, single source
        wr(6'd8, 32'd3); wr(6'd3, 32'd0); wr(6'd2, 32'hFF); wr(6'd1, 32'hFF);
        pulse(8'h01);
        idle(4);
        dchk("edge_ei_set", 32'(ei), 32'd1);
        rd(6'd4, v); dchk("edge_claim", v, 32'd1);
        idle(1);
        dchk("edge_ei_drop", 32'(ei), 32'd0);
        rd(6'd0, v); dchk("edge_pending_clr", v, 32'h0);
        wr(6'd4, 32'd1);

        // Priority and tie-break
        wr(6'd9, 32'd2); wr(6'd10, 32'd5); wr(6'd11, 32'd5);
        pulse(8'h0E);
        idle(4);
        rd(6'd4, v); dchk("prio_claim_a", v, 32'd3);
        rd(6'd4, v); dchk("prio_claim_b", v, 32'd4);
        rd(6'd4, v); dchk("prio_claim_c", v, 32'd2);
        wr(6'd4, 32'd4);
        rd(6'd4, v); dchk("prio_reclaim_none", v, 32'd0);
        wr(6'd4, 32'd3); wr(6'd4, 32'd2);

        // Threshold
        wr(6'd3, 32'd2);
        pulse(8'h02);
        idle(4);
        dchk("thresh_block", 32'(ei), 32'd0);
        wr(6'd3, 32'd1);
        idle(1);
        dchk("thresh_pass", 32'(ei), 32'd1);
        rd(6'd4, v); dchk("thresh_claim", v, 32'd2);
        wr(6'd4, 32'd2); wr(6'd3, 32'd0);

        // Level mode on src4
        wr(6'd2, 32'hEF); wr(6'd12, 32'd4);
        @(negedge clk); src[4] = 1'b1;
        idle(5);
        rd(6'd4, v); dchk("level_claim", v, 32'd5);
        idle(1);
        dchk("level_ei_drop", 32'(ei), 32'd0);
        wr(6'd4, 32'd5);
        idle(1);
        dchk("level_rerequest", 32'(ei), 32'd1);
        @(negedge clk); src[4] = 1'b0;
        idle(5);
        rd(6'd0, v); dchk("level_pending_clr", v, 32'h0);

        // New edge in the claim cycle; complete of IDs 0 and 31 ignored
        pulse(8'h01);
        idle(5);
        pulse(8'h01);
        rd(6'd4, v); dchk("simul_claim", v, 32'd1);
        rd(6'd0, v); dchk("simul_pending_kept", v, 32'h1);
        wr(6'd4, 32'd0); wr(6'd4, 32'd31);
        rd(6'd4, v); dchk("complete_bad_ids", v, 32'd0);
        wr(6'd4, 32'd1);
        rd(6'd4, v); dchk("simul_reclaim", v, 32'd1);
        wr(6'd4, 32'd1);

        // Reset during a claim
        pulse(8'h05);
        idle(5);
        rd(6'd4, v); dchk("pre_reset_claim", v, 32'd3);
        @(negedge clk); rst = 1'b1; re = 1'b1; addr = 6'd4;
        @(negedge clk); rst = 1'b0; re = 1'b0;
        dchk("reset_rdata", rdata, 32'h0);
        dchk("reset_ei", 32'(ei), 32'd0);
        dchk("reset_irq_id", 32'(irq_id), 32'd0);
        rd(6'd10, v); dchk("reset_prio", v, 32'h0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            re = 1'b0; we = 1'b0;
            rst = ($urandom_range(0, 299) == 0);
            src = src ^ N'($urandom & $urandom & $urandom);
            r = $urandom_range(0, 9);
            if (r == 4 || r == 5) begin
                re = 1'b1; addr = 6'd4;
            end else if (r == 6) begin
                re = 1'b1;
                addr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
            end else if (r == 7) begin
                we = 1'b1; addr = 6'd4;
                wdata = {$urandom_range(0, 1) == 0 ? 27'd0 : 27'($urandom), 5'($urandom_range(0, 31))};
            end else if (r == 8) begin
                we = 1'b1;
                addr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(1, 3)) : 6'($urandom_range(8, 15));
                wdata = $urandom;
            end else if (r == 9) begin
                we = 1'b1; addr = 6'($urandom_range(0, 63)); wdata = $urandom;
            end else begin
                addr = 6'($urandom_range(0, 63));
            end
        end
        @(negedge clk);
        rst = 1'b0; re = 1'b0; we = 1'b0;
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
